pll_phase_stepper: RTL and testbench

- Parametrised controller for the dynamic phase-shift port of the fractional PLL.
- Accepts a request of the form "shift counter C by K steps up/down" and sequences the PLL's cntsel/updn/phase_en/phase_done handshake K times.
- Adds timeout and loss-of-lock detection, and tracks the accumulated phase per output counter.
- Sits between the TDC calibration logic and the PLL reconfiguration port. Runs on the PLL scan clock.

---
 rtl/pll_phase_stepper_if.sv | 39 +++
 rtl/pll_phase_stepper.sv | 166 ++++++++++++++++
 tb/tb_pll_phase_stepper.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_phase_stepper_if.sv
// Request/status and PLL dynamic-phase-shift signals of pll_phase_stepper.
// master = requester / PLL side, slave = the stepper itself.
interface pll_phase_stepper_if #(
   parameter int N_CLOCKS = 3,
   parameter int CNTSEL_W = 5,
   parameter int STEP_W   = 8,
   parameter int POS_W    = 16
);
   localparam int CH_W = (N_CLOCKS > 1) ? $clog2(N_CLOCKS) : 1;

   logic                      req_valid;
   logic                      req_ready;
   logic [CH_W-1:0]           req_chan;
   logic                      req_dir;
   logic [STEP_W-1:0]         req_steps;
   logic                      pll_locked;
   logic                      phase_done;
   logic                      phase_en;
   logic                      updn;
   logic [CNTSEL_W-1:0]       cntsel;
   logic                      busy;
   logic                      done;
   logic                      err_timeout;
   logic                      err_unlock;
   logic [3:0]                state;
   logic [N_CLOCKS*POS_W-1:0] phase_pos;

   modport master (
      output req_valid, req_chan, req_dir, req_steps, pll_locked, phase_done,
      input  req_ready, phase_en, updn, cntsel, busy, done, err_timeout,
             err_unlock, state, phase_pos
   );

   modport slave (
      input  req_valid, req_chan, req_dir, req_steps, pll_locked, phase_done,
      output req_ready, phase_en, updn, cntsel, busy, done, err_timeout,
             err_unlock, state, phase_pos
   );
endinterface

// File: rtl/pll_phase_stepper.sv
// Sequences the PLL dynamic phase-shift handshake K times per request, with
// per-step timeout, loss-of-lock abort and per-counter phase accumulators.
// Define PHASE_TRACK_EN to build the accumulators; otherwise phase_pos is 0.
module pll_phase_stepper #(
   parameter int N_CLOCKS = 3,
   parameter int CNTSEL_W = 5,
   parameter int STEP_W   = 8,
   parameter int WAIT_CYC = 2,
   parameter int TIMEOUT  = 1023,
   parameter int POS_W    = 16
) (
   input logic                clk,
   input logic                reset_n,
   pll_phase_stepper_if.slave bus
);
   localparam int CH_W = (N_CLOCKS > 1) ? $clog2(N_CLOCKS) : 1;
   localparam int TW   = $clog2(TIMEOUT + 1);
   localparam int WW   = $clog2(WAIT_CYC + 1);

   typedef enum logic [3:0] {
      S_IDLE      = 4'b0000,
      S_LOCKING   = 4'b0001,
      S_SETUP     = 4'b0010,
      S_ASSERT_EN = 4'b0011,
      S_WAIT_DONE = 4'b0100,
      S_NEXT      = 4'b0101,
      S_FINISH    = 4'b1000
   } state_t;

   state_t              r_state;
   logic [CH_W-1:0]     r_chan;
   logic                r_dir;
   logic [STEP_W-1:0]   r_left;
   logic [WW-1:0]       r_wcnt;
   logic [TW-1:0]       r_tcnt;
   logic                r_phase_en;
   logic                r_updn;
   logic [CNTSEL_W-1:0] r_cntsel;
   logic                r_err_to;
   logic                r_err_ul;

   logic [CH_W-1:0]     w_chan_clamp;
   logic                w_timeout;
   logic                w_unlock;
   logic                w_wait_met;

   // Out-of-range channel requests land on the highest real counter.
   assign w_chan_clamp = (32'(bus.req_chan) >= N_CLOCKS) ? CH_W'(N_CLOCKS - 1) : bus.req_chan;
   assign w_timeout    = (r_tcnt == TW'(TIMEOUT - 1));
   assign w_unlock     = !bus.pll_locked;
   // Shared by SETUP (setup time) and ASSERT_EN (minimum phase_en width).
   assign w_wait_met   = (r_wcnt >= WW'(WAIT_CYC - 1));

   // Request sequencer: one step = SETUP -> ASSERT_EN -> WAIT_DONE -> NEXT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_chan     <= '0;
         r_dir      <= 1'b0;
         r_left     <= '0;
         r_wcnt     <= '0;
         r_tcnt     <= '0;
         r_phase_en <= 1'b0;
         r_updn     <= 1'b1;
         r_cntsel   <= '0;
         r_err_to   <= 1'b0;
         r_err_ul   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (bus.req_valid) begin
               r_chan   <= w_chan_clamp;
               r_dir    <= bus.req_dir;
               r_left   <= bus.req_steps;
               r_err_to <= 1'b0;
               r_err_ul <= 1'b0;
               r_state  <= S_LOCKING;
            end
            S_LOCKING: begin
               // A zero-step request finishes without touching the PLL.
               if (r_left == '0) r_state <= S_FINISH;
               else if (bus.pll_locked) begin
                  r_cntsel <= CNTSEL_W'(r_chan);
                  r_updn   <= r_dir;
                  r_wcnt   <= '0;
                  r_state  <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (w_unlock) begin
                  r_err_ul <= 1'b1;
                  r_state  <= S_FINISH;
               end else if (w_wait_met) begin
                  r_wcnt     <= '0;
                  r_tcnt     <= '0;
                  r_phase_en <= 1'b1;
                  r_state    <= S_ASSERT_EN;
               end else r_wcnt <= r_wcnt + 1'b1;
            end
            S_ASSERT_EN: begin
               if (w_timeout || w_unlock) begin
                  r_phase_en <= 1'b0;
                  if (w_timeout) r_err_to <= 1'b1;
                  if (w_unlock)  r_err_ul <= 1'b1;
                  r_state    <= S_FINISH;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
                  if (w_wait_met && !bus.phase_done) begin
                     r_phase_en <= 1'b0;
                     r_state    <= S_WAIT_DONE;
                  end else if (!w_wait_met) r_wcnt <= r_wcnt + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               // Timer keeps running from ASSERT_EN: the budget covers the whole step.
               if (w_timeout || w_unlock) begin
                  if (w_timeout) r_err_to <= 1'b1;
                  if (w_unlock)  r_err_ul <= 1'b1;
                  r_state <= S_FINISH;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
                  if (bus.phase_done) r_state <= S_NEXT;
               end
            end
            S_NEXT: begin
               // The PLL has completed this step, so it is counted even if lock drops now.
               r_left <= r_left - 1'b1;
               if (w_unlock) begin
                  r_err_ul <= 1'b1;
                  r_state  <= S_FINISH;
               end else if (r_left == STEP_W'(1)) r_state <= S_FINISH;
               else begin
                  r_wcnt  <= '0;
                  r_state <= S_SETUP;
               end
            end
            S_FINISH: r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

`ifdef PHASE_TRACK_EN
   logic [N_CLOCKS-1:0][POS_W-1:0] r_pos;

   // Commit one completed step to the selected counter's position (wraps).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_pos <= '0;
      else if (r_state == S_NEXT)
         r_pos[r_chan] <= r_dir ? r_pos[r_chan] + POS_W'(1) : r_pos[r_chan] - POS_W'(1);
   end

   assign bus.phase_pos = r_pos;
`else
   assign bus.phase_pos = {(N_CLOCKS*POS_W){1'b0}};
`endif

   assign bus.req_ready   = (r_state == S_IDLE);
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.done        = (r_state == S_FINISH);
   assign bus.state       = r_state;
   assign bus.phase_en    = r_phase_en;
   assign bus.updn        = r_updn;
   assign bus.cntsel      = r_cntsel;
   assign bus.err_timeout = r_err_to;
   assign bus.err_unlock  = r_err_ul;
endmodule

// File: tb/tb_pll_phase_stepper.sv
// Directed bench for pll_phase_stepper: a PLL model, a transaction-level
// phase model checked every cycle, and literal expectations per scenario.
module tb_pll_phase_stepper;
   localparam int NC  = 3;
   localparam int CW  = 5;
   localparam int SW  = 8;
   localparam int WC  = 2;
   localparam int TO  = 20;
   localparam int PW  = 4;
   localparam int CHW = 2;
`ifdef PHASE_TRACK_EN
   localparam bit TRK = 1'b1;
`else
   localparam bit TRK = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   pll_phase_stepper_if #(.N_CLOCKS(NC), .CNTSEL_W(CW), .STEP_W(SW), .POS_W(PW)) bus ();

   pll_phase_stepper #(
      .N_CLOCKS(NC), .CNTSEL_W(CW), .STEP_W(SW), .WAIT_CYC(WC), .TIMEOUT(TO), .POS_W(PW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // PLL model: phasedone falls 3 cycles after a phaseen rise, rises 5 later.
   int   pll_cnt = 0;
   logic pll_prev_en = 1'b0;
   logic pll_stuck = 1'b0;
   always @(negedge clk) begin
      if (!reset_n) begin
         pll_cnt = 0;
         pll_prev_en = 1'b0;
         bus.phase_done <= 1'b1;
      end else begin
         if (pll_cnt != 0) begin
            pll_cnt++;
            if (pll_cnt == 3) bus.phase_done <= 1'b0;
            else if (pll_cnt == 8) begin
               bus.phase_done <= 1'b1;
               pll_cnt = 0;
            end
         end else if (bus.phase_en && !pll_prev_en && !pll_stuck) pll_cnt = 1;
         pll_prev_en = bus.phase_en;
      end
   end

   // Expectations for the running request (set by the stimulus).
   logic [CHW-1:0] exp_chan = '0;
   logic           exp_dir  = 1'b0;
   logic           exp_to   = 1'b0;
   logic           exp_ul   = 1'b0;
   int             exp_pulses = 0;

   // Transaction model: every phasedone rise seen while busy is one completed step.
   logic [PW-1:0] mpos [NC];
   logic prev_en = 1'b0, prev_pd = 1'b1;
   int   rises = 0, pulses = 0, width = 0, last_width = 0;

   function automatic logic [NC*PW-1:0] model_pp();
      logic [NC*PW-1:0] v;
      v = '0;
      for (int c = 0; c < NC; c++) v[c*PW +: PW] = mpos[c];
      return TRK ? v : '0;
   endfunction

   function automatic logic [CHW-1:0] clamp(input int ch);
      return (ch >= NC) ? CHW'(NC - 1) : CHW'(ch);
   endfunction

   always @(negedge clk) begin
      if (!reset_n) begin
         for (int c = 0; c < NC; c++) mpos[c] = '0;
         rises = 0; pulses = 0; width = 0;
         prev_en = 1'b0; prev_pd = 1'b1;
      end else begin
         chk("ready_vs_busy", bus.req_ready, !bus.busy);
         if (bus.phase_en) begin
            chk("cntsel", bus.cntsel, CW'(exp_chan));
            chk("updn", bus.updn, exp_dir);
            if (!prev_en) pulses++;
            width++;
         end else if (prev_en) begin
            last_width = width;
            // aborted pulses (fall coincides with done) are exempt
            if (!bus.done) chk("en_min_width", width >= WC, 1);
            width = 0;
         end
         if (bus.busy && bus.phase_done && !prev_pd) rises++;
         if (bus.done) begin
            chk("err_timeout", bus.err_timeout, exp_to);
            chk("err_unlock", bus.err_unlock, exp_ul);
            chk("pulses", pulses, exp_pulses);
            mpos[exp_chan] = exp_dir ? mpos[exp_chan] + PW'(rises) : mpos[exp_chan] - PW'(rises);
            chk("phase_pos_done", bus.phase_pos, model_pp());
         end else if (bus.req_ready) begin
            chk("phase_pos_idle", bus.phase_pos, model_pp());
            rises = 0; pulses = 0;
         end
         prev_en = bus.phase_en;
         prev_pd = bus.phase_done;
      end
   end

   task automatic do_req(input int ch, input bit dir, input int steps, input bit eto,
                         input bit eul, input int epul, output int lat);
      exp_chan = clamp(ch); exp_dir = dir; exp_to = eto; exp_ul = eul; exp_pulses = epul;
      bus.req_chan = CHW'(ch); bus.req_dir = dir; bus.req_steps = SW'(steps);
      bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("accepted", bus.req_ready, 0);
      chk("err_cleared", {bus.err_timeout, bus.err_unlock}, 0);
      lat = 1;
      while (!bus.done && lat < 3000) begin
         @(negedge clk);
         lat++;
      end
      chk("done_seen", bus.done, 1);
      @(negedge clk);
      chk("done_one_cycle", bus.done, 0);
      chk("ready_after", bus.req_ready, 1);
   endtask

   task automatic drop_lock_on_pulse(input int n);
      int   seen;
      logic p;
      seen = 0; p = 1'b0;
      for (int c = 0; c < 2000 && seen < n; c++) begin
         @(negedge clk);
         if (bus.phase_en && !p) seen++;
         p = bus.phase_en;
      end
      bus.pll_locked = 1'b0;
      chk("unlock_pulse_reached", seen, n);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, en_seen;
      bus.req_valid = 1'b0; bus.req_chan = '0; bus.req_dir = 1'b0; bus.req_steps = '0;
      bus.pll_locked = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_phase_en", bus.phase_en, 0);
      chk("rst_updn", bus.updn, 1);
      chk("rst_cntsel", bus.cntsel, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_errs", {bus.err_timeout, bus.err_unlock}, 0);
      chk("rst_pos", bus.phase_pos, 0);
      chk("rst_state", bus.state, 0);
      chk("rst_ready", bus.req_ready, 1);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // 4 up-steps on counter 1
      do_req(1, 1'b1, 4, 1'b0, 1'b0, 4, lat);
      chk("t1_pos1", bus.phase_pos[1*PW +: PW], TRK ? 4'd4 : 4'd0);

      // zero steps: LOCKING then FINISH
      do_req(0, 1'b0, 0, 1'b0, 1'b0, 0, lat);
      chk("t2_latency", lat, 2);

      // PLL never answers: phase_en held exactly TIMEOUT cycles
      pll_stuck = 1'b1;
      do_req(0, 1'b1, 3, 1'b1, 1'b0, 1, lat);
      pll_stuck = 1'b0;
      chk("t3_en_width", last_width, 20);
      repeat (4) @(negedge clk);

      // lock lost during 3rd of 5 down-steps on counter 0
      fork
         do_req(0, 1'b0, 5, 1'b0, 1'b1, 3, lat);
         drop_lock_on_pulse(3);
      join
      bus.pll_locked = 1'b1;
      chk("t5_pos0", bus.phase_pos[0 +: PW], TRK ? 4'hE : 4'h0);
      repeat (12) @(negedge clk);

      // 9 up-steps on counter 2 wrap a 4-bit position to -7
      do_req(2, 1'b1, 9, 1'b0, 1'b0, 9, lat);
      chk("t6_wrap", bus.phase_pos[2*PW +: PW], TRK ? 4'h9 : 4'h0);

      // waits 10 cycles in LOCKING; channel 3 clamps to 2
      bus.pll_locked = 1'b0;
      fork
         do_req(3, 1'b1, 1, 1'b0, 1'b0, 1, lat);
         begin
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               chk("t4_locking", bus.state, 4'b0001);
               chk("t4_no_en", bus.phase_en, 0);
            end
            bus.pll_locked = 1'b1;
         end
      join
      chk("t4_pos2", bus.phase_pos[2*PW +: PW], TRK ? 4'hA : 4'h0);

      // asynchronous reset in the middle of a shift
      exp_chan = 2'd1; exp_dir = 1'b0; exp_to = 1'b0; exp_ul = 1'b0; exp_pulses = 3;
      bus.req_chan = 2'd1; bus.req_dir = 1'b0; bus.req_steps = 8'd3; bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      en_seen = 0;
      for (int c = 0; c < 200 && en_seen == 0; c++) begin
         @(negedge clk);
         if (bus.phase_en) en_seen = 1;
      end
      chk("t8_en_seen", en_seen, 1);
      reset_n = 1'b0;
      #1;
      chk("t8_en_cleared", bus.phase_en, 0);
      chk("t8_pos_cleared", bus.phase_pos, 0);
      chk("t8_state", bus.state, 0);
      chk("t8_busy", bus.busy, 0);
      chk("t8_updn", bus.updn, 1);
      chk("t8_cntsel", bus.cntsel, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("t8_ready", bus.req_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
